// File: rtl/elevator_car_request_panel_if.sv
// Request channel from the car panel to the car request queue.
interface elevator_car_request_panel_if #(
    parameter int unsigned FLOOR_W = 3
) ();
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;

    modport master (
        output req_valid,
        output req_floor,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_floor,
        output req_ready
    );
endinterface

// File: rtl/elevator_car_request_panel.sv
// Car panel front end: synchronises and debounces floor buttons, latches
// presses as lit pending requests and issues them round-robin to the queue.
module elevator_car_request_panel #(
    parameter int unsigned NUM_FLOORS      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FLOOR_W         = $clog2(NUM_FLOORS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_FLOORS-1:0]     buttons,
    input  logic [FLOOR_W-1:0]        current_floor,
    input  logic                      arrived,
    elevator_car_request_panel_if.master req_if,
    output logic [NUM_FLOORS-1:0]     lamps
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GAP
    } state_t;

    state_t state_q, state_d;

    logic [NUM_FLOORS-1:0] sync1_q, sync2_q;
    logic [NUM_FLOORS-1:0] deb_q, deb_d;
    logic [CNT_W-1:0]      cnt_q [NUM_FLOORS];
    logic [CNT_W-1:0]      cnt_d [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] lamps_q, lamps_d;
    logic [NUM_FLOORS-1:0] unsent_q, unsent_d;
    logic                  req_valid_q, req_valid_d;
    logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
    logic [FLOOR_W-1:0]    rr_q, rr_d;

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] arr_clr;
    logic [NUM_FLOORS-1:0] hs_clr;
    logic                  sel_found;
    logic [FLOOR_W-1:0]    sel_floor;

    // Floor index arithmetic modulo NUM_FLOORS (not necessarily a power of two).
    function automatic logic [FLOOR_W-1:0] wrap_idx(input logic [FLOOR_W-1:0] base,
                                                    input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_FLOORS) s = s - NUM_FLOORS;
        return FLOOR_W'(s);
    endfunction

    // Debounce: count consecutive synchronised samples that disagree with the
    // accepted level; a 0->1 acceptance is the press event.
    always_comb begin
        deb_d = deb_q;
        press = '0;
        cnt_d = '{default: '0};
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (sync2_q[f] != deb_q[f]) begin
                if (cnt_q[f] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[f] = sync2_q[f];
                    press[f] = sync2_q[f];
                end else begin
                    cnt_d[f] = cnt_q[f] + CNT_W'(1);
                end
            end
        end
    end

    // Arrival clears the floor the car stopped at, when that floor exists.
    always_comb begin
        arr_clr = '0;
        if (arrived && ({1'b0, current_floor} < (FLOOR_W + 1)'(NUM_FLOORS))) begin
            arr_clr[current_floor] = 1'b1;
        end
    end

    // Round-robin pick: first unsent floor at or after rr pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_floor = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (!sel_found && unsent_q[wrap_idx(rr_q, i)]) begin
                sel_found = 1'b1;
                sel_floor = wrap_idx(rr_q, i);
            end
        end
    end

    // Issue FSM: next state, offer register updates and handshake clear mask.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_floor_d = req_floor_q;
        rr_d        = rr_q;
        hs_clr      = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    req_valid_d = 1'b1;
                    req_floor_d = sel_floor;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (req_if.req_ready) begin
                    hs_clr[req_floor_q] = 1'b1;
                    rr_d                = wrap_idx(req_floor_q, 1);
                    req_valid_d         = 1'b0;
                    state_d             = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // Pending request bookkeeping; a press on a lit floor never re-queues it,
    // and arrival overrides a same-edge press.
    always_comb begin
        lamps_d  = (lamps_q | press) & ~arr_clr;
        unsent_d = (unsent_q | (press & ~lamps_q)) & ~arr_clr & ~hs_clr;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: synchronisers, debounce, requests and offer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            cnt_q       <= '{default: '0};
            lamps_q     <= '0;
            unsent_q    <= '0;
            req_valid_q <= 1'b0;
            req_floor_q <= '0;
            rr_q        <= '0;
        end else begin
            sync1_q     <= buttons;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            lamps_q     <= lamps_d;
            unsent_q    <= unsent_d;
            req_valid_q <= req_valid_d;
            req_floor_q <= req_floor_d;
            rr_q        <= rr_d;
        end
    end

    assign req_if.req_valid = req_valid_q;
    assign req_if.req_floor = req_floor_q;
    assign lamps            = lamps_q;

endmodule
